// File: rtl/counter_pkg.sv
// Shared types and constants for the countdown timer: state encoding and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its controller.
interface countdown_timer_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic             i_enable;
  logic [WIDTH-1:0] o_count;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_load,
    output i_load_value,
    output i_enable,
    input  o_count,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_load,
    input  i_load_value,
    input  i_enable,
    output o_count,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse on reaching zero.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value instead of stopping.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              resetn,
  countdown_timer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // A load wins over everything else; a zero load finishes immediately.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.i_load) begin
      count_d  = bus.i_load_value;
      reload_d = bus.i_load_value;
      if (bus.i_load_value != '0) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.i_enable) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.o_count = count_q;
  assign bus.o_busy  = (state_q == RUN);
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer plus hand sequences for reset-related corners.
module tb_countdown_timer;

  typedef struct {
    logic       load;
    logic [7:0] value;
    logic       enable;
    logic [7:0] expCount;
    logic       expBusy;
    logic       expDone;
    string      tag;
  } vec_t;

  logic clk;
  logic resetn;
  int   vecCount;
  int   missCount;
  vec_t vecs[$];

  countdown_timer_if #(.WIDTH(8)) bus ();

  countdown_timer #(.WIDTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic addVec(input logic ld, input int val, input logic en,
                        input int cnt, input logic busy, input logic done,
                        input string tag);
    vec_t v;
    v.load     = ld;
    v.value    = 8'(val);
    v.enable   = en;
    v.expCount = 8'(cnt);
    v.expBusy  = busy;
    v.expDone  = done;
    v.tag      = tag;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] cnt,
                             input logic busy, input logic done);
    vecCount++;
    if (bus.o_count !== cnt || bus.o_busy !== busy || bus.o_done !== done) begin
      missCount++;
      $display("[TB] FAIL %s (vector %0d): got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
               tag, vecCount, bus.o_count, bus.o_busy, bus.o_done, cnt, busy, done);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, sample 1 ns later.
  task automatic applyStimulus(input vec_t v);
    bus.i_load       = v.load;
    bus.i_load_value = v.value;
    bus.i_enable     = v.enable;
    @(posedge clk);
    #1;
    checkOutput(v.tag, v.expCount, v.expBusy, v.expDone);
  endtask

  task automatic buildTable();
    for (int i = 0; i < 3; i++) addVec(0, 8'hA5, 1, 0, 0, 0, "idle_after_reset");
    addVec(1, 0, 1, 0, 0, 1, "load0_done");
    addVec(0, 0, 1, 0, 0, 0, "load0_idle");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    addVec(1, 4, 1, 4, 1, 0, "ar_load4");
    for (int v = 3; v >= 1; v--) addVec(0, 0, 1, v, 1, 0, "ar_dec");
    for (int p = 0; p < 2; p++) begin
      addVec(0, 0, 1, 4, 1, 1, "ar_reload");
      for (int v = 3; v >= 1; v--) addVec(0, 0, 1, v, 1, 0, "ar_dec");
    end
    addVec(0, 0, 0, 1, 1, 0, "ar_pause");
    addVec(0, 0, 0, 1, 1, 0, "ar_pause");
    addVec(0, 0, 1, 4, 1, 1, "ar_reload_after_pause");
    addVec(1, 1, 1, 1, 1, 0, "ar_load1");
    for (int i = 0; i < 3; i++) addVec(0, 0, 1, 1, 1, 1, "ar_period1");
    addVec(1, 3, 1, 3, 1, 0, "ar_load3");
    addVec(0, 0, 1, 2, 1, 0, "ar_dec3");
    addVec(1, 0, 1, 0, 0, 1, "ar_load0_stops");
    addVec(0, 0, 1, 0, 0, 0, "ar_idle");
    addVec(0, 0, 1, 0, 0, 0, "ar_idle");
`else
    addVec(1, 5, 1, 5, 1, 0, "load5");
    for (int v = 4; v >= 1; v--) addVec(0, 0, 1, v, 1, 0, "dec5");
    addVec(0, 0, 1, 0, 0, 1, "done5");
    addVec(0, 0, 1, 0, 0, 0, "idle5");
    addVec(0, 0, 1, 0, 0, 0, "idle5");

    addVec(1, 10, 1, 10, 1, 0, "load10");
    addVec(0, 0, 1, 9, 1, 0, "dec10");
    for (int i = 0; i < 10; i++) addVec(0, 0, 0, 9, 1, 0, "pause10");
    for (int v = 8; v >= 1; v--) addVec(0, 0, 1, v, 1, 0, "dec10");
    addVec(0, 0, 1, 0, 0, 1, "done10");
    addVec(0, 0, 1, 0, 0, 0, "idle10");

    addVec(1, 200, 1, 200, 1, 0, "load200");
    for (int v = 199; v >= 150; v--) addVec(0, 0, 1, v, 1, 0, "dec200");
    addVec(1, 3, 1, 3, 1, 0, "restart3");
    addVec(0, 0, 1, 2, 1, 0, "dec3");
    addVec(0, 0, 1, 1, 1, 0, "dec3");
    addVec(0, 0, 1, 0, 0, 1, "done3");
    addVec(0, 0, 1, 0, 0, 0, "idle3");
    addVec(0, 0, 1, 0, 0, 0, "idle3");

    addVec(1, 1, 1, 1, 1, 0, "load1");
    addVec(0, 0, 1, 0, 0, 1, "done1");
    addVec(1, 2, 1, 2, 1, 0, "load_in_done");
    addVec(0, 0, 1, 1, 1, 0, "dec2");
    addVec(0, 0, 1, 0, 0, 1, "done2");
    addVec(0, 0, 1, 0, 0, 0, "idle2");

    addVec(1, 255, 1, 255, 1, 0, "load255");
    for (int v = 254; v >= 1; v--) addVec(0, 0, 1, v, 1, 0, "dec255");
    addVec(0, 0, 1, 0, 0, 1, "done255");
    addVec(0, 0, 1, 0, 0, 0, "idle255");
`endif
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    resetn           = 1'b0;
    bus.i_load       = 1'b0;
    bus.i_load_value = '0;
    bus.i_enable     = 1'b0;

    #10;
    checkOutput("in_reset", 8'd0, 1'b0, 1'b0);
    #10;
    resetn = 1'b1;

    buildTable();
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset in the middle of a run: outputs must clear before the next clock edge.
    bus.i_load       = 1'b1;
    bus.i_load_value = 8'd20;
    bus.i_enable     = 1'b1;
    @(posedge clk);
    #1;
    bus.i_load = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrun_count7", 8'd7, 1'b1, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    checkOutput("async_reset_before_edge", 8'd0, 1'b0, 1'b0);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("after_midrun_reset", 8'd0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
